// File: rtl/ysyx_24110006_lsu_axi.sv
// rtl/ysyx_24110006_lsu_axi.sv - load/store unit bridging single core requests onto an AXI4-Lite master
// One transaction in flight; misaligned requests answer with an error and never reach the bus.
module ysyx_24110006_lsu_axi #(
    parameter int STRB_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [31:0]       o_axi_araddr,
    output logic              o_axi_arvalid,
    input  logic              i_axi_arready,
    input  logic [31:0]       i_axi_rdata,
    input  logic              i_axi_rvalid,
    input  logic [1:0]        i_axi_rresp,
    output logic              o_axi_rready,
    output logic [31:0]       o_axi_awaddr,
    output logic              o_axi_awvalid,
    input  logic              i_axi_awready,
    output logic [31:0]       o_axi_wdata,
    output logic [STRB_W-1:0] o_axi_wstrb,
    output logic              o_axi_wvalid,
    input  logic              i_axi_wready,
    input  logic [1:0]        i_axi_bresp,
    input  logic              i_axi_bvalid,
    output logic              o_axi_bready
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RSP} state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;

    logic        misaligned;
    logic [3:0]  strb_base;
    logic [31:0] lane_data;
    logic [31:0] load_ext;

    always_comb begin
        misaligned = (i_req_size == 2'd3)
                  || (i_req_size == 2'd1 && i_req_addr[0])
                  || (i_req_size == 2'd2 && i_req_addr[1:0] != 2'b00);
        case (i_req_size)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
        // Aligned half loads have addr_lo of 0 or 2, so one shift serves both lane sizes.
        lane_data = i_axi_rdata >> {addr_lo_q, 3'b000};
        case (size_q)
            2'd0:    load_ext = {{24{lane_data[7] & ~unsigned_q}}, lane_data[7:0]};
            2'd1:    load_ext = {{16{lane_data[15] & ~unsigned_q}}, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    addr_lo_d   = i_req_addr[1:0];
                    size_d      = i_req_size;
                    unsigned_d  = i_req_unsigned;
                    rsp_rdata_d = '0;
                    rsp_err_d   = misaligned;
                    if (misaligned) begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_RSP;
                    end else if (i_req_wen) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = {i_req_addr[31:2], 2'b00};
                        wdata_d   = i_req_wdata << {i_req_addr[1:0], 3'b000};
                        wstrb_d   = strb_base << i_req_addr[1:0];
                        state_d   = S_AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = {i_req_addr[31:2], 2'b00};
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                if (i_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (i_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = load_ext;
                    rsp_err_d   = |i_axi_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_AW_W: begin
                // Address and data channels retire independently; leave once both are gone.
                if (i_axi_awready) awvalid_d = 1'b0;
                if (i_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_B;
                end
            end
            S_B: begin
                if (i_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = |i_axi_bresp;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_axi_araddr  = araddr_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_rready  = rready_q;
    assign o_axi_awaddr  = awaddr_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = STRB_W'(wstrb_q);
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_bready  = bready_q;
endmodule

// File: tb/tb_ysyx_24110006_lsu_axi.sv
// tb/tb_ysyx_24110006_lsu_axi.sv - randomized and directed bench for the LSU AXI4-Lite master
module tb_ysyx_24110006_lsu_axi;
    logic        i_clock, i_reset;
    logic        i_req_valid, o_req_ready, i_req_wen, i_req_unsigned;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [1:0]  i_req_size;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic [31:0] o_axi_araddr, i_axi_rdata, o_axi_awaddr, o_axi_wdata;
    logic        o_axi_arvalid, i_axi_arready, i_axi_rvalid, o_axi_rready;
    logic [1:0]  i_axi_rresp, i_axi_bresp;
    logic        o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
    logic [7:0]  o_axi_wstrb;
    logic        i_axi_bvalid, o_axi_bready;

    ysyx_24110006_lsu_axi #(.STRB_W(8)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rvalid(i_axi_rvalid), .i_axi_rresp(i_axi_rresp), .o_axi_rready(o_axi_rready),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int vectors, miscompares;

    // Observations of the most recent run_txn
    logic [31:0] obs_araddr, obs_awaddr, obs_wdata, obs_rdata;
    logic [7:0]  obs_wstrb;
    logic        obs_err, post_ready, post_rsp;
    int ar_cnt, aw_cnt, w_cnt, ar_hs, r_hs, aw_hs, w_hs, b_first, rsp_cyc, rsp_held, r_held;
    int viol, req_wait;
    logic timeout;

    function automatic int nbytes_of(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || ((addr % nbytes_of(size)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] bus, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] mask, v;
        n    = nbytes_of(size);
        mask = 32'hFFFF_FFFF >> (32 - 8 * n);
        v    = (bus >> (8 * (addr % 4))) & mask;
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input logic [31:0] addr, input logic [1:0] size);
        return 8'(((32'd1 << nbytes_of(size)) - 32'd1) << (addr % 4));
    endfunction

    function automatic logic outs_any();
        return |{o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_axi_araddr, o_axi_arvalid,
                 o_axi_rready, o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wstrb, o_axi_wvalid, o_axi_bready};
    endfunction

    task automatic clear_inputs();
        i_req_valid = 0; i_req_wen = 0; i_req_addr = 0; i_req_wdata = 0; i_req_size = 0; i_req_unsigned = 0;
        i_rsp_ready = 0; i_axi_arready = 0; i_axi_rdata = 0; i_axi_rvalid = 0; i_axi_rresp = 0;
        i_axi_awready = 0; i_axi_wready = 0; i_axi_bresp = 0; i_axi_bvalid = 0;
    endtask

    // Issues one request and acts as an AXI slave with the given wait counts, recording what it sees.
    task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input logic uns,
                           input int ar_w, input int r_w, input int aw_w, input int w_w, input int b_w,
                           input int rsp_w, input logic [31:0] bus, input logic [1:0] rresp, input logic [1:0] bresp);
        int cyc, arv, awv, wv, br;
        logic ar_done, r_done, aw_done, w_done, b_done, fin;
        logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        obs_araddr = 0; obs_awaddr = 0; obs_wdata = 0; obs_wstrb = 0; obs_rdata = 0; obs_err = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_hs = -1; r_hs = -1; aw_hs = -1; w_hs = -1; b_first = -1;
        rsp_cyc = -1; rsp_held = 0; r_held = 0; viol = 0; req_wait = 0; timeout = 0;
        arv = 0; awv = 0; wv = 0; br = 0;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0; fin = 0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0;
        while (!o_req_ready && req_wait < 20) begin
            @(posedge i_clock); #1; req_wait++;
        end
        i_req_valid = 1; i_req_wen = wen; i_req_addr = addr; i_req_wdata = wd;
        i_req_size = size; i_req_unsigned = uns;
        @(posedge i_clock); #1;
        i_req_valid = 0;
        cyc = 1;
        while (!fin && cyc < 300) begin
            i_axi_arready = 0; i_axi_rvalid = 0; i_axi_rresp = 0; i_axi_rdata = $urandom;
            i_axi_awready = 0; i_axi_wready = 0; i_axi_bvalid = 0; i_axi_bresp = 0; i_rsp_ready = 0;
            if (o_req_ready) viol++;
            if (o_axi_rready) begin
                if (!ar_done || r_done) viol++;
                if (r_held >= r_w) begin
                    i_axi_rvalid = 1; i_axi_rdata = bus; i_axi_rresp = rresp; r_done = 1; r_hs = cyc;
                end
                r_held++;
            end else if (ar_done && !r_done) viol++;
            if (o_axi_bready) begin
                if (!(aw_done && w_done) || b_done) viol++;
                if (b_first < 0) b_first = cyc;
                if (br >= b_w) begin
                    i_axi_bvalid = 1; i_axi_bresp = bresp; b_done = 1;
                end
                br++;
            end else if (aw_done && w_done && !b_done) viol++;
            if (p_arv && !p_arr && (!o_axi_arvalid || o_axi_araddr !== p_araddr)) viol++;
            if (o_axi_arvalid) begin
                if (ar_done) viol++;
                obs_araddr = o_axi_araddr; ar_cnt++;
                i_axi_arready = (arv >= ar_w); arv++;
                if (i_axi_arready) begin ar_done = 1; ar_hs = cyc; end
            end
            if (p_awv && !p_awr && (!o_axi_awvalid || o_axi_awaddr !== p_awaddr)) viol++;
            if (o_axi_awvalid) begin
                if (aw_done) viol++;
                obs_awaddr = o_axi_awaddr; aw_cnt++;
                i_axi_awready = (awv >= aw_w); awv++;
                if (i_axi_awready) begin aw_done = 1; aw_hs = cyc; end
            end
            if (p_wv && !p_wr && (!o_axi_wvalid || o_axi_wdata !== p_wdata)) viol++;
            if (o_axi_wvalid) begin
                if (w_done) viol++;
                obs_wdata = o_axi_wdata; obs_wstrb = o_axi_wstrb; w_cnt++;
                i_axi_wready = (wv >= w_w); wv++;
                if (i_axi_wready) begin w_done = 1; w_hs = cyc; end
            end
            p_arv = o_axi_arvalid; p_arr = i_axi_arready; p_araddr = o_axi_araddr;
            p_awv = o_axi_awvalid; p_awr = i_axi_awready; p_awaddr = o_axi_awaddr;
            p_wv = o_axi_wvalid; p_wr = i_axi_wready; p_wdata = o_axi_wdata;
            if (o_rsp_valid) begin
                if (rsp_held == 0) begin
                    rsp_cyc = cyc; obs_rdata = o_rsp_rdata; obs_err = o_rsp_err;
                end else if (o_rsp_rdata !== obs_rdata || o_rsp_err !== obs_err) viol++;
                i_rsp_ready = (rsp_held >= rsp_w);
                rsp_held++;
                if (i_rsp_ready) fin = 1;
            end else if (rsp_held > 0) viol++;
            @(posedge i_clock); #1; cyc++;
        end
        clear_inputs();
        timeout = !fin;
        post_ready = o_req_ready;
        post_rsp = o_rsp_valid;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_reset = 0;
        repeat (3) @(posedge i_clock);
        #1; vectors++;
        if (outs_any() !== 1'b0) begin miscompares++; $display("FAIL reset_outputs: got nonzero, expected all 0"); end
        #2 i_reset = 1;
        #1; vectors++;
        if (o_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_before_edge: got %b expected 0", o_req_ready); end
        @(posedge i_clock); #1; vectors++;
        if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after_edge: got %b expected 1", o_req_ready); end
    endtask

    task automatic test_lb_sign();
        run_txn(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 0, 0, 0, 0, 0, 0, 32'h80FF_FF12, 2'b00, 2'b00);
        vectors += 6;
        if (obs_araddr !== 32'h8000_0000) begin miscompares++; $display("FAIL lb_araddr: got %h expected 80000000", obs_araddr); end
        if (obs_rdata !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_rdata: got %h expected ffffff80", obs_rdata); end
        if (obs_err !== 1'b0) begin miscompares++; $display("FAIL lb_err: got %b expected 0", obs_err); end
        if (rsp_cyc !== 3) begin miscompares++; $display("FAIL lb_rsp_cycle: got %0d expected 3", rsp_cyc); end
        if (ar_hs !== 1 || r_hs !== 2) begin miscompares++; $display("FAIL lb_hs_cycles: got ar %0d r %0d expected 1 2", ar_hs, r_hs); end
        if (viol !== 0 || timeout !== 1'b0) begin miscompares++; $display("FAIL lb_protocol: got viol %0d timeout %b expected 0 0", viol, timeout); end
    endtask

    task automatic test_sh();
        run_txn(1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
        vectors += 6;
        if (obs_awaddr !== 32'h8000_0000) begin miscompares++; $display("FAIL sh_awaddr: got %h expected 80000000", obs_awaddr); end
        if (obs_wdata !== 32'hBEEF_0000) begin miscompares++; $display("FAIL sh_wdata: got %h expected beef0000", obs_wdata); end
        if (obs_wstrb !== 8'h0C) begin miscompares++; $display("FAIL sh_wstrb: got %h expected 0c", obs_wstrb); end
        if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin miscompares++; $display("FAIL sh_rsp: got %h/%b expected 0/0", obs_rdata, obs_err); end
        if (rsp_cyc !== 3 || ar_cnt !== 0) begin miscompares++; $display("FAIL sh_timing: got rsp %0d ar %0d expected 3 0", rsp_cyc, ar_cnt); end
        if (viol !== 0 || timeout !== 1'b0) begin miscompares++; $display("FAIL sh_protocol: got viol %0d timeout %b expected 0 0", viol, timeout); end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00);
        vectors += 4;
        if (ar_cnt !== 0 || aw_cnt !== 0 || w_cnt !== 0) begin miscompares++; $display("FAIL mis_bus: got ar %0d aw %0d w %0d expected 0 0 0", ar_cnt, aw_cnt, w_cnt); end
        if (obs_err !== 1'b1) begin miscompares++; $display("FAIL mis_err: got %b expected 1", obs_err); end
        if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL mis_rdata: got %h expected 0", obs_rdata); end
        if (rsp_cyc !== 1 || timeout !== 1'b0) begin miscompares++; $display("FAIL mis_rsp_cycle: got %0d expected 1", rsp_cyc); end
    endtask

    task automatic test_store_split();
        run_txn(1'b1, 32'h8000_0010, 32'h1234_5678, 2'd2, 1'b0, 0, 0, 0, 3, 0, 0, 32'h0, 2'b00, 2'b00);
        vectors += 4;
        if (aw_hs !== 1 || aw_cnt !== 1) begin miscompares++; $display("FAIL split_aw: got hs %0d cycles %0d expected 1 1", aw_hs, aw_cnt); end
        if (w_hs !== 4 || w_cnt !== 4) begin miscompares++; $display("FAIL split_w: got hs %0d cycles %0d expected 4 4", w_hs, w_cnt); end
        if (b_first !== 5) begin miscompares++; $display("FAIL split_bready: got %0d expected 5", b_first); end
        if (viol !== 0 || timeout !== 1'b0) begin miscompares++; $display("FAIL split_protocol: got viol %0d timeout %b expected 0 0", viol, timeout); end
    endtask

    task automatic test_load_err_wait();
        run_txn(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 0, 5, 0, 0, 0, 3, 32'hCAFE_F00D, 2'b10, 2'b00);
        vectors += 5;
        if (r_held !== 6) begin miscompares++; $display("FAIL lerr_rready_cycles: got %0d expected 6", r_held); end
        if (obs_err !== 1'b1) begin miscompares++; $display("FAIL lerr_err: got %b expected 1", obs_err); end
        if (rsp_held !== 4) begin miscompares++; $display("FAIL lerr_rsp_held: got %0d expected 4", rsp_held); end
        if (rsp_cyc !== 8) begin miscompares++; $display("FAIL lerr_rsp_cycle: got %0d expected 8", rsp_cyc); end
        if (viol !== 0 || timeout !== 1'b0) begin miscompares++; $display("FAIL lerr_protocol: got viol %0d timeout %b expected 0 0", viol, timeout); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 32'h0000_0102, 32'h0, 2'd1, 1'b1, 0, 0, 0, 0, 0, 0, 32'h8001_7FFF, 2'b00, 2'b00);
        vectors += 3;
        if (obs_rdata !== 32'h0000_8001) begin miscompares++; $display("FAIL b2b_first_rdata: got %h expected 00008001", obs_rdata); end
        if (post_ready !== 1'b1 || post_rsp !== 1'b0) begin miscompares++; $display("FAIL b2b_after_rsp: got ready %b valid %b expected 1 0", post_ready, post_rsp); end
        run_txn(1'b1, 32'h0000_0203, 32'h0000_00A5, 2'd0, 1'b0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b01);
        if (req_wait !== 0 || obs_err !== 1'b1 || obs_wstrb !== 8'h08) begin
            miscompares++; $display("FAIL b2b_second: got wait %0d err %b strb %h expected 0 1 08", req_wait, obs_err, obs_wstrb);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_inputs();
        i_req_valid = 1; i_req_addr = 32'h8000_0020; i_req_size = 2'd2;
        @(posedge i_clock); #1;
        i_req_valid = 0; i_axi_arready = 1;
        @(posedge i_clock); #1;
        i_axi_arready = 0;
        vectors++;
        if (o_axi_rready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_r: got rready %b expected 1", o_axi_rready); end
        #2 i_reset = 0;
        #1; vectors++;
        if (outs_any() !== 1'b0) begin miscompares++; $display("FAIL rmid_outputs_zero: got nonzero expected all 0"); end
        @(posedge i_clock); #3 i_reset = 1;
        @(posedge i_clock); #1; vectors++;
        if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b expected 1", o_req_ready); end
        seen = 0;
        i_axi_rvalid = 1; i_axi_rdata = 32'h1111_2222; i_axi_bvalid = 1;
        for (int k = 0; k < 10; k++) begin
            if (o_rsp_valid || o_axi_arvalid || o_axi_rready) seen++;
            @(posedge i_clock); #1;
        end
        clear_inputs();
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL rmid_no_rsp: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_random();
        logic wen, uns, mis;
        logic [1:0] size, rresp, bresp;
        logic [31:0] addr, wd, bus, exp_rdata;
        int ar_w, r_w, aw_w, w_w, b_w, rsp_w, exp_cyc;
        for (int i = 0; i < 60; i++) begin
            wen = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            wd = $urandom; bus = $urandom;
            ar_w = $urandom_range(0, 3); r_w = $urandom_range(0, 3); aw_w = $urandom_range(0, 3);
            w_w = $urandom_range(0, 3); b_w = $urandom_range(0, 3); rsp_w = $urandom_range(0, 2);
            rresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(wen, addr, wd, size, uns, ar_w, r_w, aw_w, w_w, b_w, rsp_w, bus, rresp, bresp);
            mis = model_misaligned(addr, size);
            if (mis) exp_cyc = 1;
            else if (!wen) exp_cyc = 3 + ar_w + r_w;
            else exp_cyc = 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w;
            vectors += 3;
            if (viol !== 0 || timeout !== 1'b0) begin miscompares++; $display("FAIL rand%0d_protocol: got viol %0d timeout %b expected 0 0", i, viol, timeout); end
            if (rsp_cyc !== exp_cyc) begin miscompares++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, rsp_cyc, exp_cyc); end
            if (post_ready !== 1'b1) begin miscompares++; $display("FAIL rand%0d_ready_after: got %b expected 1", i, post_ready); end
            if (mis) begin
                vectors++;
                if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || ar_cnt + aw_cnt + w_cnt != 0) begin
                    miscompares++; $display("FAIL rand%0d_mis: got err %b rdata %h bus %0d expected 1 0 0", i, obs_err, obs_rdata, ar_cnt + aw_cnt + w_cnt);
                end
            end else if (!wen) begin
                exp_rdata = model_load(bus, addr, size, uns);
                vectors += 3;
                if (obs_araddr !== (addr & ~32'd3)) begin miscompares++; $display("FAIL rand%0d_araddr: got %h expected %h", i, obs_araddr, addr & ~32'd3); end
                if (obs_rdata !== exp_rdata) begin miscompares++; $display("FAIL rand%0d_rdata: got %h expected %h", i, obs_rdata, exp_rdata); end
                if (obs_err !== (rresp != 0) || aw_cnt != 0) begin miscompares++; $display("FAIL rand%0d_lerr: got %b aw %0d expected %b 0", i, obs_err, aw_cnt, rresp != 0); end
            end else begin
                vectors += 4;
                if (obs_awaddr !== (addr & ~32'd3)) begin miscompares++; $display("FAIL rand%0d_awaddr: got %h expected %h", i, obs_awaddr, addr & ~32'd3); end
                if (obs_wdata !== (wd << (8 * (addr % 4)))) begin miscompares++; $display("FAIL rand%0d_wdata: got %h expected %h", i, obs_wdata, wd << (8 * (addr % 4))); end
                if (obs_wstrb !== model_strb(addr, size)) begin miscompares++; $display("FAIL rand%0d_wstrb: got %h expected %h", i, obs_wstrb, model_strb(addr, size)); end
                if (obs_err !== (bresp != 0) || obs_rdata !== 32'h0 || ar_cnt != 0) begin
                    miscompares++; $display("FAIL rand%0d_serr: got %b rdata %h ar %0d expected %b 0 0", i, obs_err, obs_rdata, ar_cnt, bresp != 0);
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        test_reset();
        test_lb_sign();
        test_sh();
        test_misaligned();
        test_store_split();
        test_load_err_wait();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ysyx_24110006_lsu_axi.md
YSYX_24110006_LSU_AXI -- requirements
Module: ysyx_24110006_lsu_axi

Interface
REQ-001 SHALL have parameter STRB_W, default 8, giving the o_axi_wstrb width; bits [STRB_W-1:4] are always 0.
REQ-002 SHALL have port i_clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have core request ports:
- i_req_valid, input, 1
- o_req_ready, output, 1
- i_req_wen, input, 1: 1 = store
- i_req_addr, input, 32
- i_req_wdata, input, 32: store data, right-aligned
- i_req_size, input, 2: 0 = byte, 1 = half, 2 = word
- i_req_unsigned, input, 1: load zero-extends.
REQ-005 SHALL have core response ports: o_rsp_valid (output, 1), i_rsp_ready (input, 1), o_rsp_rdata (output, 32: extended load data), o_rsp_err (output, 1).
REQ-006 SHALL have AXI4-Lite master ports:
- o_axi_araddr (32), o_axi_arvalid, i_axi_arready
- i_axi_rdata (32), i_axi_rvalid, i_axi_rresp (2), o_axi_rready
- o_axi_awaddr (32), o_axi_awvalid, i_axi_awready
- o_axi_wdata (32), o_axi_wstrb (STRB_W), o_axi_wvalid, i_axi_wready
- i_axi_bresp (2), i_axi_bvalid, o_axi_bready.

Function
REQ-007 SHALL implement FSM states IDLE, AR, R, AW_W, B, RSP; all outputs registered or decoded from state only.
REQ-008 SHALL assert o_req_ready only in IDLE; handshake = i_req_valid & o_req_ready captures addr, wdata, size, unsigned, wen.
REQ-009 SHALL treat as misaligned: half with addr[0]=1, word with addr[1:0]!=0, size=3. Such a request goes IDLE->RSP with err=1 and rdata=0, with no bus activity.
REQ-010 SHALL, for an aligned load, go IDLE->AR: o_axi_arvalid=1, araddr = addr with [1:0] cleared; arvalid and araddr held stable until i_axi_arready.
REQ-011 SHALL, on the AR handshake, go AR->R: o_axi_rready=1. On i_axi_rvalid, capture rdata and rresp, then go to RSP.
REQ-012 SHALL select load lane by addr[1:0]: byte = rdata[8*a+7:8*a], half = rdata[16*a[1]+15:16*a[1]]; sign-extend unless unsigned; word passes through.
REQ-013 SHALL, for an aligned store, go IDLE->AW_W: assert o_axi_awvalid and o_axi_wvalid together; awaddr word-aligned; each valid drops independently after its own handshake; go to B when both are done, including same-cycle completion.
REQ-014 SHALL form store data by lane shift: wdata = i_req_wdata << (8*addr[1:0]). Strobe is 4'b0001, 4'b0011 or 4'b1111 (byte/half/word), shifted left by addr[1:0].
REQ-015 SHALL, in B, assert o_axi_bready; on i_axi_bvalid capture bresp, then go to RSP.
REQ-016 SHALL, in RSP, hold o_rsp_valid=1 with stable rdata and err until i_rsp_ready, then return to IDLE; back-to-back requests are accepted from the next cycle.
REQ-017 SHALL set o_rsp_err=1 when the captured rresp or bresp is nonzero. Store responses return rdata=0.
REQ-018 SHALL never deassert an AXI valid before its handshake and never hold more than one transaction outstanding.
REQ-019 SHALL give minimum latency against a zero-wait slave (ready=1, response one cycle later): request accepted at cycle 0, AR/AW handshake at cycle 1, R/B at cycle 2, o_rsp_valid at cycle 3.

Reset
REQ-020 SHALL, while i_reset=0, asynchronously force state=IDLE and all outputs to 0. The only exception is o_req_ready, which asserts 1 at the first clock edge after release.
REQ-021 SHALL abandon any in-flight transaction on reset assertion mid-operation, with no response issued afterwards.

Verification
REQ-022 SHALL cover an lb at addr 0x8000_0003 with unsigned=0 and slave rdata 0x80FF_FF12 -> araddr 0x8000_0000, o_rsp_rdata 0xFFFF_FF80, err=0, rsp_valid at cycle 3.
REQ-023 SHALL cover an sh at 0x8000_0002 with wdata 0x0000_BEEF -> awaddr 0x8000_0000, wdata 0xBEEF_0000, wstrb 0x0C.
REQ-024 SHALL cover a lw at 0x8000_0001 -> no arvalid ever asserted, rsp err=1, rdata 0.
REQ-025 SHALL cover a store where the slave gives awready at cycle 1 and wready at cycle 4 -> awvalid low from cycle 2, wvalid held until cycle 4, bready from cycle 5.
REQ-026 SHALL cover a load with rresp=2'b10, rvalid delayed 5 cycles, and i_rsp_ready held low for 3 cycles -> rready held throughout the wait, err=1, rsp_valid held stable for 3 cycles.
REQ-027 SHALL cover reset asserted in state R -> all outputs 0 immediately; after release, o_req_ready=1 and no response is emitted.
